block_sched: RTL and testbench

//  Block-level round-robin scheduler for the 16-channel -> one 16-bit serial-link datapath.

---
 rtl/blksched_pkg.sv | 21 ++
 rtl/rr_pick16.sv | 29 ++
 rtl/block_sched.sv | 199 +++++++++++++++++++
 tb/tb_block_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blksched_pkg.sv
// blksched_pkg: shared definitions for the block scheduler.
//   COMMA / TRIG / ABORT : link K-characters (always sent with kchar=1)
//   state_t              : scheduler FSM encoding
//   LEN_W_DEF            : default width of the header length field
//   HDR_LEN_LSB          : bit position of the length field inside a header word
package blksched_pkg;

    localparam logic [15:0] COMMA = 16'h00BC;   // K28.5, idle fill
    localparam logic [15:0] TRIG  = 16'h801C;   // K28.0, out-of-band trigger
    localparam logic [15:0] ABORT = 16'h807C;   // K28.3, stalled block abandoned

    localparam int LEN_W_DEF   = 10;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        END  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: combinational rotating priority encoder over 16 requesters.
//   mask  in  16  candidate requesters
//   start in  4   index searched first; search wraps 15 -> 0
//   valid out 1   some bit of mask is set
//   idx   out 4   first set bit at or after start (0 when !valid)
module rr_pick16 (
    input  logic [15:0] mask,
    input  logic [3:0]  start,
    output logic        valid,
    output logic [3:0]  idx
);

    logic [3:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        cand  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            // 4-bit addition wraps naturally from 15 back to 0
            cand = start + 4'(i);
            if (!valid && mask[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/block_sched.sv
// block_sched: block-level round-robin scheduler feeding a 16-bit serial link.
// A whole channel block (header + len payload words) is sent before another
// channel is considered. Trigger K-chars preempt any slot, commas fill gaps,
// and a block stalled for TMO+1 consecutive cycles is closed with ABORT.
//
// Optional feature macro: BLKSCHED_CSUM_EN -- when defined, each completed
// block is followed by a 16-bit sum (mod 2^16) of header and payload words.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   data       in   16*NCH   channel words, chan i on data[16*i +: 16]
//   req        in   NCH      chan i has a word on its slice
//   ack        out  NCH      one-hot pop strobe (combinational)
//   chan_en    in   NCH      enable mask, used only when choosing a block
//   trigger    in   1        trigger request pulse
//   dout       out  16       registered link word
//   kchar      out  1        dout is a K-character
//   busy       out  1        a block is in progress
//   cur_chan   out  4        owner of current / last block
//   err_cnt    out  8        aborted blocks, saturating
//   trig_lost  out  8        triggers dropped while one was pending, saturating
module block_sched
    import blksched_pkg::*;
#(
    parameter int NCH   = 16,
    parameter int LEN_W = LEN_W_DEF,
    parameter int TMO   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [16*NCH-1:0] data,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    ack,
    input  logic [NCH-1:0]    chan_en,
    input  logic              trigger,
    output logic [15:0]       dout,
    output logic              kchar,
    output logic              busy,
    output logic [3:0]        cur_chan,
    output logic [7:0]        err_cnt,
    output logic [7:0]        trig_lost
);

    localparam int                 STALL_W   = $clog2(TMO + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TMO);

`ifdef BLKSCHED_CSUM_EN
    localparam state_t LAST_NEXT = END;
`else
    // Without a checksum slot the last payload word returns straight to IDLE.
    localparam state_t LAST_NEXT = IDLE;
`endif

    state_t             state, state_n;
    logic [3:0]         cur_n;
    logic [LEN_W-1:0]   len, len_n;
    logic [STALL_W-1:0] stall, stall_n;
    logic [15:0]        dout_n;
    logic               kchar_n;
    logic [7:0]         err_n, trig_lost_n;
    logic               trig_pend, trig_pend_n;
    logic [NCH-1:0]     ack_c;
    logic [15:0]        words [NCH];
    logic [15:0]        cur_word, pick_word;
    logic               pick_valid;
    logic [3:0]         pick_idx;
`ifdef BLKSCHED_CSUM_EN
    logic [15:0]        csum, csum_n;
`endif

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            words[i] = data[16*i +: 16];
        end
    end

    // Search starts one past the last owner, so the previous winner is
    // considered last and cannot win twice while others are waiting.
    rr_pick16 u_pick (
        .mask  (req & chan_en),
        .start (cur_chan + 4'd1),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_word = words[pick_idx];
    assign cur_word  = words[cur_chan];
    assign busy      = (state != IDLE);
    // Nothing is popped while reset is held, even though the FSM sits in IDLE.
    assign ack       = rst_n ? ack_c : '0;

    always_comb begin
        state_n     = state;
        cur_n       = cur_chan;
        len_n       = len;
        stall_n     = stall;
        dout_n      = COMMA;
        kchar_n     = 1'b1;
        err_n       = err_cnt;
        trig_lost_n = trig_lost;
        trig_pend_n = trig_pend;
        ack_c       = '0;
`ifdef BLKSCHED_CSUM_EN
        csum_n      = csum;
`endif

        if (trigger && trig_pend && trig_lost != 8'hFF) begin
            trig_lost_n = trig_lost + 8'd1;
        end

        if (trig_pend) begin
            // Trigger slot: FSM, stall counter and pops are all frozen.
            trig_pend_n = 1'b0;
            dout_n      = TRIG;
        end else begin
            trig_pend_n = trigger;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        ack_c[pick_idx] = 1'b1;
                        dout_n          = pick_word;
                        kchar_n         = 1'b0;
                        cur_n           = pick_idx;
                        len_n           = pick_word[HDR_LEN_LSB +: LEN_W];
                        stall_n         = '0;
`ifdef BLKSCHED_CSUM_EN
                        csum_n          = pick_word;
`endif
                        state_n = (len_n == '0) ? LAST_NEXT : DATA;
                    end
                end
                DATA: begin
                    if (req[cur_chan]) begin
                        ack_c[cur_chan] = 1'b1;
                        dout_n          = cur_word;
                        kchar_n         = 1'b0;
                        len_n           = len - LEN_W'(1);
                        stall_n         = '0;
`ifdef BLKSCHED_CSUM_EN
                        csum_n          = csum + cur_word;
`endif
                        if (len == LEN_W'(1)) begin
                            state_n = LAST_NEXT;
                        end
                    end else if (stall == STALL_MAX) begin
                        dout_n  = ABORT;
                        stall_n = '0;
                        state_n = IDLE;
                        if (err_cnt != 8'hFF) begin
                            err_n = err_cnt + 8'd1;
                        end
                    end else begin
                        stall_n = stall + STALL_W'(1);
                    end
                end
`ifdef BLKSCHED_CSUM_EN
                END: begin
                    dout_n  = csum;
                    kchar_n = 1'b0;
                    state_n = IDLE;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_chan  <= 4'd0;
            len       <= '0;
            stall     <= '0;
            dout      <= COMMA;
            kchar     <= 1'b1;
            err_cnt   <= 8'd0;
            trig_lost <= 8'd0;
            trig_pend <= 1'b0;
`ifdef BLKSCHED_CSUM_EN
            csum      <= 16'd0;
`endif
        end else begin
            state     <= state_n;
            cur_chan  <= cur_n;
            len       <= len_n;
            stall     <= stall_n;
            dout      <= dout_n;
            kchar     <= kchar_n;
            err_cnt   <= err_n;
            trig_lost <= trig_lost_n;
            trig_pend <= trig_pend_n;
`ifdef BLKSCHED_CSUM_EN
            csum      <= csum_n;
`endif
        end
    end

endmodule

// File: tb/tb_block_sched.sv
// tb_block_sched: directed bench for block_sched. Each channel is modelled as
// a small word FIFO; req/data follow the FIFO head and a word is popped after
// every edge at which ack was high. Expected values are hand-computed.
`timescale 1ns/1ps
module tb_block_sched;
    import blksched_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] data;
    logic [15:0]  req;
    logic [15:0]  ack;
    logic [15:0]  chan_en;
    logic         trigger;
    logic [15:0]  dout;
    logic         kchar;
    logic         busy;
    logic [3:0]   cur_chan;
    logic [7:0]   err_cnt;
    logic [7:0]   trig_lost;

    always #5 clk = ~clk;

    block_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .req       (req),
        .ack       (ack),
        .chan_en   (chan_en),
        .trigger   (trigger),
        .dout      (dout),
        .kchar     (kchar),
        .busy      (busy),
        .cur_chan  (cur_chan),
        .err_cnt   (err_cnt),
        .trig_lost (trig_lost)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] cmem [16][8];
    int          cwr [16];
    int          crd [16];
    logic [15:0] ack_s;
    int          seq [$];
    int          exp_ord [6] = '{15, 15, 0, 0, 5, 5};
    int          cnt;
    int          got_ord;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic update_bus();
        for (int i = 0; i < 16; i++) begin
            if (crd[i] < cwr[i]) begin
                req[i]           = 1'b1;
                data[16*i +: 16] = cmem[i][crd[i]];
            end else begin
                req[i]           = 1'b0;
                data[16*i +: 16] = 16'h0000;
            end
        end
    endtask

    task automatic push(input int ch, input logic [15:0] w);
        cmem[ch][cwr[ch]] = w;
        cwr[ch]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < 16; i++) begin
            cwr[i] = 0;
            crd[i] = 0;
        end
        update_bus();
    endtask

    // One clock: capture ack mid-cycle, then pop what was taken at the edge.
    task automatic step();
        @(negedge clk);
        ack_s = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            if (ack_s[i]) crd[i]++;
        end
        update_bus();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        trigger = 1'b0;
        chan_en = 16'hFFFF;
        req     = '0;
        data    = '0;
        clear_q();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dout",   {15'd0, kchar, dout}, {15'd0, 1'b1, COMMA});
        check("rst_busy",   busy, 0);
        check("rst_cur",    cur_chan, 0);
        check("rst_err",    err_cnt, 0);
        check("rst_tlost",  trig_lost, 0);
        check("rst_ack",    ack, 0);
        rst_n = 1'b1;
        step();

        // 1: chan 3, len 2
        push(3, 16'h0002); push(3, 16'hAAAA); push(3, 16'hBBBB); update_bus();
        step();
        check("t1_ack_hdr", ack_s, 16'h0008);
        check("t1_hdr",     {kchar, dout}, {1'b0, 16'h0002});
        check("t1_cur",     cur_chan, 3);
        check("t1_busy",    busy, 1);
        step();
        check("t1_ack_a",   ack_s, 16'h0008);
        check("t1_a",       {kchar, dout}, {1'b0, 16'hAAAA});
        step();
        check("t1_ack_b",   ack_s, 16'h0008);
        check("t1_b",       {kchar, dout}, {1'b0, 16'hBBBB});
        step();
        check("t1_ack_end", ack_s, 16'h0000);
`ifdef BLKSCHED_CSUM_EN
        check("t1_csum",    {kchar, dout}, {1'b0, 16'h6667});
        step();
`endif
        check("t1_comma",   {kchar, dout}, {1'b1, COMMA});
        check("t1_busy_lo", busy, 0);

        // 2: make chan 5 the last owner, then 0, 5, 15 all hold blocks
        push(5, 16'h0000); update_bus();
        step();
        check("t2_pre_ack", ack_s, 16'h0020);
        repeat (2) step();
        check("t2_pre_cur", cur_chan, 5);
        push(0, 16'h0001); push(0, 16'h1000);
        push(5, 16'h0001); push(5, 16'h5000);
        push(15, 16'h0001); push(15, 16'hF000);
        update_bus();
        for (int c = 0; c < 12; c++) begin
            step();
            for (int i = 0; i < 16; i++) begin
                if (ack_s[i]) seq.push_back(i);
            end
        end
        check("t2_nacks", seq.size(), 6);
        for (int k = 0; k < 6; k++) begin
            got_ord = (k < seq.size()) ? seq[k] : -1;
            check($sformatf("t2_order%0d", k), got_ord, exp_ord[k]);
        end

        // 3: trigger mid-block on chan 9, len 4
        push(9, 16'h0004); push(9, 16'h9001); push(9, 16'h9002);
        push(9, 16'h9003); push(9, 16'h9004); update_bus();
        step();
        check("t3_ack_hdr", ack_s, 16'h0200);
        check("t3_hdr",     {kchar, dout}, {1'b0, 16'h0004});
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("t3_w1",      {kchar, dout}, {1'b0, 16'h9001});
        step();
        check("t3_trig_ack", ack_s, 16'h0000);
        check("t3_trig",    {kchar, dout}, {1'b1, TRIG});
        step();
        check("t3_w2",      {kchar, dout}, {1'b0, 16'h9002});
        step();
        check("t3_w3",      {kchar, dout}, {1'b0, 16'h9003});
        step();
        check("t3_ack_w4",  ack_s, 16'h0200);
        check("t3_w4",      {kchar, dout}, {1'b0, 16'h9004});
        repeat (2) step();
        trigger = 1'b1;
        step();
        step();
        trigger = 1'b0;
        check("t3_trig2",   {kchar, dout}, {1'b1, TRIG});
        check("t3_lost",    trig_lost, 1);
        step();
        check("t3_after",   {kchar, dout}, {1'b1, COMMA});

        // 4: chan 7 stalls after 1 of 3 payload words
        push(7, 16'h0003); push(7, 16'h7001); update_bus();
        step();
        check("t4_ack_hdr", ack_s, 16'h0080);
        check("t4_hdr",     {kchar, dout}, {1'b0, 16'h0003});
        step();
        check("t4_w1",      {kchar, dout}, {1'b0, 16'h7001});
        push(2, 16'h8000); update_bus();
        cnt = 0;
        repeat (255) begin
            step();
            if (dout == COMMA && kchar == 1'b1 && ack_s == 16'h0000) cnt++;
        end
        check("t4_commas",  cnt, 255);
        step();
        check("t4_abort",   {kchar, dout}, {1'b1, ABORT});
        check("t4_err",     err_cnt, 1);
        check("t4_busy",    busy, 0);
        step();
        check("t4_next_ack", ack_s, 16'h0004);
        check("t4_next",    {kchar, dout}, {1'b0, 16'h8000});
        repeat (2) step();

        // 5: only chan 0 enabled while everyone requests; then reset mid-block
        for (int ch = 0; ch < 16; ch++) begin
            push(ch, 16'h0001);
            push(ch, 16'hC000 + 16'(ch));
        end
        chan_en = 16'h0001;
        update_bus();
        step();
        check("t5_ack_hdr", ack_s, 16'h0001);
        check("t5_hdr",     {kchar, dout}, {1'b0, 16'h0001});
        step();
        check("t5_ack_w",   ack_s, 16'h0001);
        check("t5_w",       {kchar, dout}, {1'b0, 16'hC000});
        step();
        check("t5_ack_0a",  ack_s, 16'h0000);
        step();
        check("t5_ack_0b",  ack_s, 16'h0000);
        check("t5_idle",    {kchar, dout}, {1'b1, COMMA});
        chan_en = 16'hFFFF;
        step();
        check("t5_ack_ch1", ack_s, 16'h0002);
        check("t5_busy",    busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_dout", {kchar, dout}, {1'b1, COMMA});
        check("t5_rst_ack",  ack, 16'h0000);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_cur",  cur_chan, 0);
        clear_q();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 6: header 0x0002 + 0x0010 + 0xFFF0 on chan 4
        push(4, 16'h0002); push(4, 16'h0010); push(4, 16'hFFF0); update_bus();
        step();
        check("t6_ack_hdr", ack_s, 16'h0010);
        check("t6_hdr",     {kchar, dout}, {1'b0, 16'h0002});
        step();
        check("t6_w1",      {kchar, dout}, {1'b0, 16'h0010});
        step();
        check("t6_w2",      {kchar, dout}, {1'b0, 16'hFFF0});
        step();
        check("t6_ack_end", ack_s, 16'h0000);
`ifdef BLKSCHED_CSUM_EN
        check("t6_csum",    {kchar, dout}, {1'b0, 16'h0002});
`else
        check("t6_tail",    {kchar, dout}, {1'b1, COMMA});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
